// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter shared definitions.
// Port ids, read-tag bundle and latency bound.
package dmem_arbiter_pkg;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  function automatic bit read_lat_ok(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the DataMem arbiter.
// master = requester, slave = arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/dmem_rd_tracker.sv
// Read-tag delay line matching DataMem latency.
// Output tag lines up with mem_douta.
module dmem_rd_tracker
  import dmem_arbiter_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t in_tag,
  output rd_tag_t out_tag
);

  if (!read_lat_ok(READ_LAT)) begin : g_lat_chk
    $error("dmem_rd_tracker: READ_LAT out of range");
  end

  rd_tag_t pipe [READ_LAT];

  // Shift tags one stage per cycle; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= in_tag;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out_tag = pipe[READ_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port DataMem
// between the CPU memory stage and the debug/DMA loader.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave p0,
  dmem_arbiter_if.slave p1,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dina,
  input  logic [DW-1:0] mem_douta
);

  logic          last_grant;
  logic          gnt0;
  logic          gnt1;
  logic          granted;
  logic          sel;
  logic          sel_we;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] dina_q;
  rd_tag_t       rd_in;
  rd_tag_t       rd_out;

  // Pick a winner; on contention the port that lost last time wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        (p0.req && p1.req): begin
          gnt0 = (last_grant == PORT_DBG);
          gnt1 = (last_grant == PORT_CPU);
        end
        (p0.req && !p1.req): gnt0 = 1'b1;
        (!p0.req && p1.req): gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign granted = gnt0 | gnt1;
  assign sel     = gnt1 ? PORT_DBG : PORT_CPU;
  assign sel_we  = sel ? p1.we : p0.we;

  // Drive DataMem from the winner; hold the bus when idle.
  always_comb begin
    mem_wea  = 1'b0;
    mem_addr = addr_q;
    mem_dina = dina_q;
    if (granted) begin
      mem_wea  = sel_we;
      mem_addr = sel ? p1.addr : p0.addr;
      mem_dina = sel ? p1.wdata : p0.wdata;
    end
  end

  // Remember last winner and last bus value.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_DBG;
      addr_q     <= '0;
      dina_q     <= '0;
    end else if (granted) begin
      last_grant <= sel;
      addr_q     <= mem_addr;
      dina_q     <= mem_dina;
    end
  end

  assign rd_in.valid = granted & ~sel_we;
  assign rd_in.id    = sel;

  dmem_rd_tracker #(
    .READ_LAT (READ_LAT)
  ) u_rd_tracker (
    .clk     (clk),
    .rst     (rst),
    .in_tag  (rd_in),
    .out_tag (rd_out)
  );

  assign p0.ready  = gnt0;
  assign p1.ready  = gnt1;
  assign p0.rvalid = rd_out.valid & ~rst & (rd_out.id == PORT_CPU);
  assign p1.rvalid = rd_out.valid & ~rst & (rd_out.id == PORT_DBG);
  assign p0.rdata  = mem_douta;
  assign p1.rdata  = mem_douta;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two DUTs (READ_LAT 1 and 3)
// share one random stimulus stream and a behavioural memory model.
module tb_dmem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          life;
  } op_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    longint      due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];

  logic        obs_ready  [2][2];
  logic        obs_rvalid [2][2];
  logic [31:0] obs_rdata  [2][2];
  logic        obs_wea    [2];
  logic [31:0] obs_addr   [2];
  logic [31:0] obs_dina   [2];

  op_t    opq [2][$];
  op_t    cur [2];
  bit     cur_v [2];
  bit     acc [2];
  bit     last;
  bit     rnd_idle;
  exp_t   sb [2][$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] hold_addr;
  bit     hold_ok;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT_A : LAT_B;

    dmem_arbiter_if #(.AW(32), .DW(32)) pa ();
    dmem_arbiter_if #(.AW(32), .DW(32)) pb ();

    logic        wea;
    logic [31:0] maddr;
    logic [31:0] mdina;
    logic [31:0] mdouta;
    logic [31:0] ram [256];
    logic [31:0] dq [LAT];

    assign pa.req   = req_v[0];
    assign pa.we    = we_v[0];
    assign pa.addr  = addr_v[0];
    assign pa.wdata = wdata_v[0];
    assign pb.req   = req_v[1];
    assign pb.we    = we_v[1];
    assign pb.addr  = addr_v[1];
    assign pb.wdata = wdata_v[1];

    dmem_arbiter #(
      .AW       (32),
      .DW       (32),
      .READ_LAT (LAT)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .p0        (pa),
      .p1        (pb),
      .mem_wea   (wea),
      .mem_addr  (maddr),
      .mem_dina  (mdina),
      .mem_douta (mdouta)
    );

    initial begin
      for (int i = 0; i < 256; i++) ram[i] = '0;
      for (int i = 0; i < LAT; i++) dq[i] = '0;
    end

    // write-first single-port RAM with LAT-cycle read
    always @(posedge clk) begin
      if (wea) ram[maddr[7:0]] <= mdina;
      dq[0] <= wea ? mdina : ram[maddr[7:0]];
      for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
    end

    assign mdouta = dq[LAT-1];

    assign obs_ready[g][0]  = pa.ready;
    assign obs_ready[g][1]  = pb.ready;
    assign obs_rvalid[g][0] = pa.rvalid;
    assign obs_rvalid[g][1] = pb.rvalid;
    assign obs_rdata[g][0]  = pa.rdata;
    assign obs_rdata[g][1]  = pb.rdata;
    assign obs_wea[g]       = wea;
    assign obs_addr[g]      = maddr;
    assign obs_dina[g]      = mdina;
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic logic [31:0] mm_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Issue side: reference arbitration, bus checks, expectation push.
  always @(negedge clk) begin
    bit g0;
    bit g1;
    int gp;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (rst) begin
      last    = 1'b1;
      hold_ok = 1'b0;
      for (int d = 0; d < 2; d++) begin
        sb[d].delete();
        chk($sformatf("rst_ready0_d%0d", d), obs_ready[d][0], 0);
        chk($sformatf("rst_ready1_d%0d", d), obs_ready[d][1], 0);
        chk($sformatf("rst_wea_d%0d", d), obs_wea[d], 0);
      end
    end else begin
      g0 = req_v[0] && (!req_v[1] || last == 1'b1);
      g1 = req_v[1] && (!req_v[0] || last == 1'b0);
      gp = g1 ? 1 : 0;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ready0_d%0d", d), obs_ready[d][0], g0);
        chk($sformatf("ready1_d%0d", d), obs_ready[d][1], g1);
        chk($sformatf("wea_d%0d", d), obs_wea[d],
            (g0 || g1) && we_v[gp]);
        if (g0 || g1) begin
          chk($sformatf("addr_d%0d", d), obs_addr[d], addr_v[gp]);
          if (we_v[gp])
            chk($sformatf("dina_d%0d", d), obs_dina[d], wdata_v[gp]);
        end else if (hold_ok) begin
          chk($sformatf("addr_hold_d%0d", d), obs_addr[d], hold_addr);
        end
      end
      if (g0 || g1) begin
        acc[gp]   = 1'b1;
        last      = gp[0];
        hold_addr = addr_v[gp];
        hold_ok   = 1'b1;
        if (we_v[gp]) begin
          model_mem[addr_v[gp]] = wdata_v[gp];
        end else begin
          for (int d = 0; d < 2; d++)
            sb[d].push_back('{gp, mm_read(addr_v[gp]), cyc + lat_of(d)});
        end
      end
    end
  end

  // Monitor: pop and compare whenever a DUT returns read data.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (obs_rvalid[d][p]) begin
          if (rst || sb[d].size() == 0) begin
            chk($sformatf("spurious_rvalid%0d_d%0d", p, d),
                obs_rvalid[d][p], 0);
          end else begin
            e = sb[d].pop_front();
            chk($sformatf("rport_d%0d", d), p, e.port);
            chk($sformatf("rdata_d%0d", d), obs_rdata[d][p], e.data);
            chk($sformatf("rcycle_d%0d", d), cyc, e.due);
          end
        end
      end
      if (!rst) begin
        while (sb[d].size() > 0 && sb[d][0].due < cyc) begin
          e = sb[d].pop_front();
          chk($sformatf("rvalid_timeout_d%0d", d), cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (cur_v[p]) begin
        if (acc[p]) begin
          cur_v[p] = 1'b0;
        end else if (cur[p].life > 0) begin
          cur[p].life--;
          if (cur[p].life == 0) cur_v[p] = 1'b0;
        end
      end
      if (!cur_v[p] && opq[p].size() > 0 &&
          !(rnd_idle && $urandom_range(0, 3) == 0)) begin
        cur[p]   = opq[p].pop_front();
        cur_v[p] = 1'b1;
      end
      req_v[p]   = cur_v[p];
      we_v[p]    = cur[p].we;
      addr_v[p]  = cur[p].addr;
      wdata_v[p] = cur[p].data;
    end
  endtask

  task automatic push_op(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] dat, input int life);
    opq[p].push_back('{we, a, dat, life});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((opq[0].size() > 0 || opq[1].size() > 0 || cur_v[0] ||
            cur_v[1] || sb[0].size() > 0 || sb[1].size() > 0) &&
           n < budget) begin
      tick();
      n++;
    end
    chk("drain_budget", n < budget, 1);
    repeat (4) tick();
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    rnd_idle = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_v[p]   = 1'b0;
      we_v[p]    = 1'b0;
      addr_v[p]  = '0;
      wdata_v[p] = '0;
      cur_v[p]   = 1'b0;
      cur[p]     = '{1'b0, 32'h0, 32'h0, 0};
    end

    // reset with both ports requesting, then port 0 first
    push_op(0, 1'b0, 32'h04, 32'h0, 0);
    push_op(1, 1'b0, 32'h08, 32'h0, 0);
    tick();
    tick();
    rst = 1'b0;
    drain(50);

    // single port write then read
    push_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    push_op(0, 1'b0, 32'h10, 32'h0, 0);
    drain(50);

    // contention: both ports stream reads
    for (int i = 0; i < 3; i++) begin
      push_op(0, 1'b0, 32'h10, 32'h0, 0);
      push_op(1, 1'b0, 32'h20 + i, 32'h0, 0);
    end
    drain(50);

    // p1 write stalled behind p0 read stream
    for (int i = 0; i < 6; i++) push_op(0, 1'b0, i, 32'h0, 0);
    push_op(1, 1'b1, 32'h30, 32'hCAFEF00D, 0);
    push_op(1, 1'b0, 32'h30, 32'h0, 0);
    drain(50);

    // reset right after a read is accepted
    push_op(0, 1'b0, 32'h10, 32'h0, 0);
    n = 0;
    do begin
      tick();
      @(negedge clk);
      #1;
      n++;
    end while (!acc[0] && n < 20);
    chk("midflight_accept", acc[0], 1);
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drain(50);

    // back-to-back reads of 0x0..0x7
    for (int i = 0; i < 8; i++) push_op(0, 1'b0, i, 32'h0, 0);
    drain(50);

    // randomized mix with idles and dropped requests
    rnd_idle = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 200; i++) begin
        push_op(p, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 15)), $urandom(),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0);
      end
    end
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
